// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types and helpers for the IMEM/DMEM APB arbiter.
package apb_mem_arbiter_pkg;

  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMEM = 2'd1,
    GNT_DMEM = 2'd2
  } arb_gnt_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] max);
    return (cnt >= max) ? max : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/apb_mem_arbiter_if.sv
// APB bus bundle; master drives the request side, slave drives the response side.
interface apb_if
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DAT_W  = 32
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DAT_W-1:0]  pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DAT_W-1:0]  prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mem_arbiter_prio_sbm.sv
// Winner selection with a starvation counter that bounds consecutive DMEM grants.
module apb_arb_prio_sbm
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned DMEM_MAX_CONSEC = 4
)(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     idle_i,
  input  logic     imem_req_i,
  input  logic     dmem_req_i,
  input  logic     grant_take_i,
  output arb_gnt_e winner_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(DMEM_MAX_CONSEC);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    winner_o = GNT_NONE;
    if (imem_req_i && dmem_req_i) begin
      winner_o = (starve_cnt_q == MAX_C) ? GNT_IMEM : GNT_DMEM;
    end else if (dmem_req_i) begin
      winner_o = GNT_DMEM;
    end else if (imem_req_i) begin
      winner_o = GNT_IMEM;
    end
  end

  // Only idle cycles touch the counter; it holds across a transfer.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle_i) begin
      if (!imem_req_i) begin
        starve_cnt_d = '0;
      end else if (grant_take_i) begin
        if (winner_o == GNT_IMEM) begin
          starve_cnt_d = '0;
        end else if (winner_o == GNT_DMEM) begin
          starve_cnt_d = sat_inc(starve_cnt_q, MAX_C);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one memory APB slave between fetch (IMEM) and load/store (DMEM) masters.
module apb_mem_arbiter
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DAT_W           = 32,
  parameter int unsigned DMEM_MAX_CONSEC = 4
)(
  input  logic     clk,
  input  logic     rst_n,
  apb_if.slave     imem_apb,
  apb_if.slave     dmem_apb,
  apb_if.master    mem_apb,
  output arb_gnt_e gnt_o,
  output logic     busy_o
);

  arb_state_e state_q, state_d;
  arb_gnt_e   gnt_q, gnt_d, winner;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       idle, grant_take;
  logic       unused_penable;

  assign idle           = (state_q == ST_IDLE);
  assign grant_take     = idle && (imem_apb.psel || dmem_apb.psel);
  assign unused_penable = imem_apb.penable | dmem_apb.penable;

  apb_arb_prio_sbm #(
    .DMEM_MAX_CONSEC (DMEM_MAX_CONSEC)
  ) u_prio (
    .clk          (clk),
    .rst_n        (rst_n),
    .idle_i       (idle),
    .imem_req_i   (imem_apb.psel),
    .dmem_req_i   (dmem_apb.psel),
    .grant_take_i (grant_take),
    .winner_o     (winner)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_take) begin
          state_d = ST_SETUP;
          gnt_d   = winner;
        end else begin
          gnt_d = GNT_NONE;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_apb.pready) begin
          state_d = ST_IDLE;
          gnt_d   = GNT_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_NONE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = psel_q;

  always_comb begin
    mem_apb.psel    = psel_q;
    mem_apb.penable = penable_q;
    mem_apb.pwrite  = 1'b0;
    mem_apb.paddr   = '0;
    mem_apb.pwdata  = '0;
    mem_apb.pstrb   = '0;
    if (gnt_q == GNT_IMEM) begin
      mem_apb.pwrite = imem_apb.pwrite;
      mem_apb.paddr  = imem_apb.paddr;
      mem_apb.pwdata = imem_apb.pwdata;
      mem_apb.pstrb  = imem_apb.pstrb;
    end else if (gnt_q == GNT_DMEM) begin
      mem_apb.pwrite = dmem_apb.pwrite;
      mem_apb.paddr  = dmem_apb.paddr;
      mem_apb.pwdata = dmem_apb.pwdata;
      mem_apb.pstrb  = dmem_apb.pstrb;
    end
  end

  always_comb begin
    imem_apb.pready  = 1'b0;
    imem_apb.prdata  = '0;
    imem_apb.pslverr = 1'b0;
    dmem_apb.pready  = 1'b0;
    dmem_apb.prdata  = '0;
    dmem_apb.pslverr = 1'b0;
    if (gnt_q == GNT_IMEM) begin
      imem_apb.pready  = penable_q & mem_apb.pready;
      imem_apb.prdata  = mem_apb.prdata;
      imem_apb.pslverr = mem_apb.pslverr;
    end else if (gnt_q == GNT_DMEM) begin
      dmem_apb.pready  = penable_q & mem_apb.pready;
      dmem_apb.prdata  = mem_apb.prdata;
      dmem_apb.pslverr = mem_apb.pslverr;
    end
  end

  a_psel_fall: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(mem_apb.psel) |-> $past(mem_apb.pready));

  a_gnt_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (busy_o && $past(busy_o)) |-> $stable(gnt_o));

  a_access_stable: assert property (@(posedge clk) disable iff (!rst_n)
    penable_q |-> ($stable(mem_apb.paddr) && $stable(mem_apb.pwdata) &&
                   $stable(mem_apb.pwrite) && $stable(mem_apb.pstrb)));

  a_imem_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (psel_q && gnt_q == GNT_IMEM) |-> imem_apb.psel);

  a_dmem_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (psel_q && gnt_q == GNT_DMEM) |-> dmem_apb.psel);

endmodule
